// File: rtl/display_scan_controller_pkg.sv
// display_scan_controller_pkg: shared state encoding and slot/BCD constants for the display scanner.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_e;

    localparam logic [1:0] SLOT_US = 2'd0;
    localparam logic [1:0] SLOT_TS = 2'd1;
    localparam logic [1:0] SLOT_UM = 2'd2;
    localparam logic [1:0] SLOT_TM = 2'd3;
    localparam int         BCD_MAX = 9;

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// scan_timer: loadable down-counter; done is high while the count sits at zero.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              count_q <= '0;
        else if (load_i)         count_q <= val_i;
        else if (count_q != '0)  count_q <= count_q - 1'b1;
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes four frame-snapshotted BCD digits onto one bus with
// guard intervals, leading-zero blanking, invalid-digit suppression and per-slot blink.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int SHOW_CYCLES  = 25000,
    parameter int GUARD_CYCLES = 64,
    parameter int BLINK_FRAMES = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [SIZE-1:0] units_second,
    input  logic [SIZE-1:0] tens_second,
    input  logic [SIZE-1:0] units_minute,
    input  logic [SIZE-1:0] tens_minute,
    input  logic            blank_lz,
    input  logic [3:0]      blink_mask,
    output logic [SIZE-1:0] bcd_out,
    output logic [3:0]      digit_en,
    output logic [1:0]      slot,
    output logic            frame_start
);

    localparam int CW = $clog2((SHOW_CYCLES > GUARD_CYCLES ? SHOW_CYCLES : GUARD_CYCLES) + 1);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    state_e                 state_q, state_d;
    logic [1:0]             slot_q, slot_d, nxt;
    logic [SIZE-1:0]        bcd_q, bcd_d, nd;
    logic [3:0]             en_q, en_d;
    logic                   fs_q, fs_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   blink_q, blink_d;
    logic [3:0][SIZE-1:0]   snap_q, snap_d, live;
    logic                   t_load, t_done, sup;
    logic [CW-1:0]          t_val;

    scan_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (t_load),
        .val_i  (t_val),
        .done_o (t_done)
    );

    assign live = {tens_minute, units_minute, tens_second, units_second};
    assign nxt  = slot_q + 2'd1;
    // Entering slot 0 always takes the live units digit, which is what the snapshot captures on that edge.
    assign nd   = (state_q == IDLE || slot_q == SLOT_TM) ? units_second : snap_q[nxt];
    assign sup  = (blink_mask[slot_q] && !blink_q) ||
                  (slot_q == SLOT_TM && blank_lz && snap_q[SLOT_TM] == '0) ||
                  (snap_q[slot_q] > SIZE'(BCD_MAX));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bcd_d   = bcd_q;
        en_d    = en_q;
        fs_d    = 1'b0;
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        snap_d  = snap_q;
        t_load  = 1'b0;
        t_val   = '0;
        if (!enable) begin
            state_d = IDLE;
            slot_d  = SLOT_US;
            bcd_d   = '0;
            en_d    = '0;
            t_load  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GUARD;
                    slot_d  = SLOT_US;
                    snap_d  = live;
                    bcd_d   = (nd > SIZE'(BCD_MAX)) ? '0 : nd;
                    fs_d    = 1'b1;
                    t_load  = 1'b1;
                    t_val   = CW'(GUARD_CYCLES - 1);
                end
                GUARD: if (t_done) begin
                    state_d = SHOW;
                    en_d    = sup ? 4'b0000 : 4'b0001 << slot_q;
                    t_load  = 1'b1;
                    t_val   = CW'(SHOW_CYCLES - 1);
                end
                SHOW: if (t_done) begin
                    state_d = GUARD;
                    slot_d  = nxt;
                    en_d    = '0;
                    bcd_d   = (nd > SIZE'(BCD_MAX)) ? '0 : nd;
                    t_load  = 1'b1;
                    t_val   = CW'(GUARD_CYCLES - 1);
                    if (slot_q == SLOT_TM) begin
                        snap_d  = live;
                        fs_d    = 1'b1;
                        fcnt_d  = (fcnt_q == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt_q + 1'b1;
                        blink_d = (fcnt_q == FW'(BLINK_FRAMES - 1)) ? !blink_q : blink_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            bcd_q   <= '0;
            en_q    <= '0;
            fs_q    <= 1'b0;
            fcnt_q  <= '0;
            blink_q <= 1'b1;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bcd_q   <= bcd_d;
            en_q    <= en_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_en    = en_q;
    assign slot        = slot_q;
    assign frame_start = fs_q;

endmodule
